passthru_slice: RTL and testbench



---
 rtl/passthru_slice_pkg.sv | 21 ++
 rtl/passthru_slice_chan.sv | 113 +++++++++++
 rtl/passthru_slice.sv | 45 ++++
 tb/tb_passthru_slice.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/passthru_slice_pkg.sv
// Sizing helpers and defaults shared by the passthru_slice top and its channel slice.
package passthru_slice_pkg;

    localparam int DEFAULT_DEPTH = 32'sd2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        if (w < 32'sd1) begin
            return 32'sd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/passthru_slice_chan.sv
// Single-channel DEPTH-entry valid/ready FIFO slice with synchronous flush.
// Optional sticky protocol checker is built when PASSTHRU_SLICE_PROTO_CHK_EN is defined.
module passthru_slice_chan
    import passthru_slice_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              empty,
    output logic              err
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_s, pop_s;

    // Ready comes only from the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (count_q < FULL_CNT) & ~flush;
    assign out_valid = (count_q != {CW{1'b0}});
    assign out_data  = mem_q[rd_ptr_q];
    assign empty     = (count_q == {CW{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Next-state: flush wins; otherwise pointers wrap at DEPTH-1 and count tracks push minus pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = {CW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= {CW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage is deliberately left unreset; out_data is only meaningful with out_valid.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef PASSTHRU_SLICE_PROTO_CHK_EN
    logic              stall_q;
    logic [DATA_W-1:0] held_data_q;
    logic              err_q;

    // A stalled offer must stay valid with stable data; violations latch until reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q     <= 1'b0;
            held_data_q <= {DATA_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            stall_q     <= in_valid & ~in_ready;
            held_data_q <= in_data;
            if (stall_q & (~in_valid | (in_data != held_data_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/passthru_slice.sv
// NCH independent valid/ready FIFO slices replacing a flat pass-through boundary.
// Define PASSTHRU_SLICE_PROTO_CHK_EN to build the per-channel sticky protocol checkers.
module passthru_slice
    import passthru_slice_pkg::*;
#(
    parameter int NCH    = 16,
    parameter int DATA_W = 1,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  idle,
    output logic [NCH-1:0]        err
);
    logic [NCH-1:0] empty_s;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        passthru_slice_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .in_valid  (in_valid[c]),
            .in_ready  (in_ready[c]),
            .in_data   (in_data[c*DATA_W +: DATA_W]),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c]),
            .out_data  (out_data[c*DATA_W +: DATA_W]),
            .empty     (empty_s[c]),
            .err       (err[c])
        );
    end

    assign idle = &empty_s;

endmodule

// File: tb/tb_passthru_slice.sv
// Bench for passthru_slice: a DEPTH=2 and a DEPTH=3 instance checked against queue-based models.
module tb_passthru_slice;
    localparam int NCH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush_v [2];
    logic [15:0] inv [2];
    logic [15:0] inr [2];
    logic [15:0] ind [2];
    logic [15:0] outv [2];
    logic [15:0] outr [2];
    logic [15:0] outd [2];
    logic [15:0] errv [2];
    logic        idle_v [2];

    int          dep [2] = '{2, 3};
    bit          mq [2][NCH][$];
    logic [15:0] err_m [2];
`ifdef PASSTHRU_SLICE_PROTO_CHK_EN
    logic [15:0] stall_m [2];
    logic [15:0] lastd_m [2];
`endif
    bit          pops [$];
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [15:0] iv;
        logic [15:0] id;
        logic [15:0] orr;
        logic        fl;
        logic [15:0] e_ir;
        logic [15:0] e_ov;
        logic [15:0] e_od;
        logic        e_idle;
    } vec_t;
    vec_t tbl [12];

    always #5 clock = ~clock;

    passthru_slice #(.NCH(16), .DATA_W(1), .DEPTH(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .flush(flush_v[0]),
        .in_valid(inv[0]), .in_ready(inr[0]), .in_data(ind[0]),
        .out_valid(outv[0]), .out_ready(outr[0]), .out_data(outd[0]),
        .idle(idle_v[0]), .err(errv[0])
    );

    passthru_slice #(.NCH(16), .DATA_W(1), .DEPTH(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .flush(flush_v[1]),
        .in_valid(inv[1]), .in_ready(inr[1]), .in_data(ind[1]),
        .out_valid(outv[1]), .out_ready(outr[1]), .out_data(outd[1]),
        .idle(idle_v[1]), .err(errv[1])
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_ready(input int k);
        logic [15:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (mq[k][c].size() < dep[k]) && !flush_v[k];
        return r;
    endfunction

    function automatic logic [15:0] exp_valid(input int k);
        logic [15:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (mq[k][c].size() != 0);
        return r;
    endfunction

    function automatic logic [15:0] exp_data(input int k);
        logic [15:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (mq[k][c].size() != 0) ? mq[k][c][0] : 1'b0;
        return r;
    endfunction

    function automatic logic exp_idle(input int k);
        logic r;
        r = 1'b1;
        for (int c = 0; c < NCH; c++) if (mq[k][c].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic check_model(input int k);
        logic [15:0] v;
        v = exp_valid(k);
        cmp($sformatf("dut%0d in_ready", k), inr[k], exp_ready(k));
        cmp($sformatf("dut%0d out_valid", k), outv[k], v);
        cmp($sformatf("dut%0d out_data", k), outd[k] & v, exp_data(k));
        cmp($sformatf("dut%0d idle", k), idle_v[k], exp_idle(k));
        cmp($sformatf("dut%0d err", k), errv[k], err_m[k]);
    endtask

    // Advance the reference model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit rdy, vld, psh, pp;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) begin
                rdy = (mq[k][c].size() < dep[k]) && !flush_v[k];
                vld = (mq[k][c].size() != 0);
                psh = inv[k][c] && rdy;
                pp  = vld && outr[k][c];
`ifdef PASSTHRU_SLICE_PROTO_CHK_EN
                if (stall_m[k][c] && (!inv[k][c] || (ind[k][c] != lastd_m[k][c]))) err_m[k][c] = 1'b1;
                stall_m[k][c] = inv[k][c] && !rdy;
                lastd_m[k][c] = ind[k][c];
`endif
                if (pp && k == 1 && c == 0) pops.push_back(mq[k][c][0]);
                if (flush_v[k]) begin
                    mq[k][c].delete();
                end else begin
                    if (pp) void'(mq[k][c].pop_front());
                    if (psh) mq[k][c].push_back(ind[k][c]);
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_model(0);
        check_model(1);
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            inv[k] = 16'h0000; ind[k] = 16'h0000; outr[k] = 16'h0000; flush_v[k] = 1'b0;
        end
    endtask

    initial begin
        logic [9:0]  beats;
        logic [15:0] prev_stall [2];
        int          idx, guard;
        bit          acc;

        tbl[0]  = '{16'h0028, 16'h0020, 16'h0008, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[1]  = '{16'h0028, 16'h0008, 16'h0008, 1'b0, 16'hFFFF, 16'h0028, 16'h0020, 1'b0};
        tbl[2]  = '{16'h0028, 16'h0020, 16'h0008, 1'b0, 16'hFFDF, 16'h0028, 16'h0028, 1'b0};
        tbl[3]  = '{16'h0028, 16'h0028, 16'h0028, 1'b0, 16'hFFDF, 16'h0028, 16'h0020, 1'b0};
        tbl[4]  = '{16'h0028, 16'h0020, 16'h0028, 1'b0, 16'hFFFF, 16'h0028, 16'h0008, 1'b0};
        tbl[5]  = '{16'h0008, 16'h0008, 16'h0028, 1'b0, 16'hFFFF, 16'h0028, 16'h0020, 1'b0};
        tbl[6]  = '{16'h0000, 16'h0000, 16'h0028, 1'b0, 16'hFFFF, 16'h0008, 16'h0008, 1'b0};
        tbl[7]  = '{16'h0000, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[8]  = '{16'h0001, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[9]  = '{16'h0001, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0001, 16'h0001, 1'b0};
        tbl[10] = '{16'h0001, 16'h0001, 16'h0001, 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0};
        tbl[11] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};

        for (int k = 0; k < 2; k++) begin
            err_m[k] = 16'h0000;
`ifdef PASSTHRU_SLICE_PROTO_CHK_EN
            stall_m[k] = 16'h0000;
            lastd_m[k] = 16'h0000;
`endif
        end
        clear_inputs();
        reset_n = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("reset in_ready", inr[k], 16'hFFFF);
            cmp("reset out_valid", outv[k], 16'h0000);
            cmp("reset idle", idle_v[k], 1'b1);
            cmp("reset err", errv[k], 16'h0000);
        end

        // Directed table on the DEPTH=2 instance: ch3 streaming, ch5 backpressure, ch0 flush collision.
        for (int i = 0; i < 12; i++) begin
            inv[0] = tbl[i].iv; ind[0] = tbl[i].id; outr[0] = tbl[i].orr; flush_v[0] = tbl[i].fl;
            #1;
            cmp($sformatf("tbl%0d in_ready", i), inr[0], tbl[i].e_ir);
            cmp($sformatf("tbl%0d out_valid", i), outv[0], tbl[i].e_ov);
            cmp($sformatf("tbl%0d out_data", i), outd[0] & tbl[i].e_ov, tbl[i].e_od);
            cmp($sformatf("tbl%0d idle", i), idle_v[0], tbl[i].e_idle);
            tick();
        end
        clear_inputs();

        // DEPTH=3 wrap: ten beats on ch0 with pops stalled every other cycle.
        beats = 10'b1101001110;
        idx = 0;
        guard = 0;
        pops.delete();
        while ((pops.size() < 10) && (guard < 200)) begin
            inv[1][0]  = (idx < 10);
            ind[1][0]  = (idx < 10) ? beats[idx] : 1'b0;
            outr[1][0] = (guard % 2 == 1);
            acc = inv[1][0] && (mq[1][0].size() < dep[1]);
            tick();
            if (acc) idx++;
            guard++;
        end
        cmp("wrap beats popped", pops.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < pops.size()) cmp($sformatf("wrap beat %0d", i), pops[i], beats[i]);
        end
        clear_inputs();
        tick();

`ifdef PASSTHRU_SLICE_PROTO_CHK_EN
        inv[0][7] = 1'b1; ind[0][7] = 1'b1; outr[0][7] = 1'b0;
        repeat (3) tick();
        inv[0][7] = 1'b0;
        tick();
        #1;
        cmp("err7 set", errv[0][7], 1'b1);
        flush_v[0] = 1'b1;
        tick();
        flush_v[0] = 1'b0;
        tick();
        #1;
        cmp("err7 sticky after flush", errv[0][7], 1'b1);
`else
        #1;
        cmp("err tied dut0", errv[0], 16'h0000);
        cmp("err tied dut1", errv[1], 16'h0000);
`endif
        clear_inputs();
        tick();

        // Random traffic with a well-behaved producer that holds stalled offers.
        prev_stall[0] = 16'h0000;
        prev_stall[1] = 16'h0000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (!prev_stall[k][c]) begin
                        inv[k][c] = ($urandom_range(0, 99) < 60);
                        ind[k][c] = $urandom_range(0, 1);
                    end
                    outr[k][c] = ($urandom_range(0, 99) < 70);
                end
                flush_v[k] = ($urandom_range(0, 99) < 2);
                prev_stall[k] = inv[k] & ~exp_ready(k);
            end
            tick();
        end
        clear_inputs();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
